exe_serial_alu: RTL and testbench
=================================

EXE_SERIAL_ALU -- requirements
Module: exe_serial_alu

Interface
REQ-001 SHALL have parameter RF_ADDR_W, default 5: register-file address width.
REQ-002 SHALL have parameter HALF_W, default 16: datapath half-word width; the full operand is 2*HALF_W bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  upstream half-word is valid.
REQ-006 ready_o  output  1  block accepts a half-word this cycle.
REQ-007 first_half_i  input  1  1 = lower half (bits HALF_W-1:0); 0 = upper half.
REQ-008 alu_op_i  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 PASS_A, 8 BEQ, 9 BNE, 10 BLT, 11 BGE, 12 BLTU, 13 BGEU, 14-15 reserved.
REQ-009 alu_a_i  input  HALF_W  operand A half.
REQ-010 alu_b_i  input  HALF_W  operand B half.
REQ-011 rd_i  input  RF_ADDR_W  destination register.
REQ-012 rf_write_i  input  1  instruction writes the register file.
REQ-013 rf_we_o  output  1  register-file half write strobe.
REQ-014 rf_waddr_o  output  RF_ADDR_W  write address.
REQ-015 rf_wdata_o  output  HALF_W  write data.
REQ-016 rf_whalf_o  output  1  0 = lower half, 1 = upper half.
REQ-017 br_valid_o  output  1  branch decision valid; one-cycle pulse.
REQ-018 br_taken_o  output  1  branch decision; meaningful only when br_valid_o = 1.
REQ-019 err_o  output  1  sticky protocol or opcode error.

Function
REQ-020 SHALL implement an FSM with states LO (expect lower half), HI (expect upper half) and FLUSH (SLT/SLTU lower-half write-back).
REQ-021 ready_o SHALL be 1 in LO and HI and 0 in FLUSH.
REQ-022 A half-word SHALL be accepted only when valid_i && ready_o; without acceptance, no state or output register changes, except that pulse outputs return to 0.
REQ-023 LO accept with first_half_i = 1:
- latch alu_op_i, rd_i, rf_write_i;
- latch carry-out and lower-equal flag (alu_a_i == alu_b_i);
- go to HI.
REQ-024 HI accept with first_half_i = 0 SHALL use the latched op and rd, not the current inputs, and go to LO; for SLT/SLTU it SHALL go to FLUSH instead. FLUSH SHALL go to LO unconditionally after one cycle.
REQ-025 Carry rules:
- ADD: lower carry-in 0; upper uses latched carry.
- SUB and all compares: B is inverted; lower carry-in 1; upper uses latched carry.
- Carry out of the upper half is discarded (mod 2^(2*HALF_W)).
REQ-026 AND, OR, XOR, PASS_A SHALL be bitwise per half. PASS_A result = alu_a_i.
REQ-027 Less-than SHALL be computed on the upper accept:
- signed: sign(A) != sign(B) ? sign(A) : sign(difference);
- unsigned: NOT carry-out.
REQ-028 Equal = latched lower-equal AND upper halves equal.
REQ-029 Write-back latency SHALL be 1 cycle: the edge after each accept registers rf_we_o, rf_waddr_o, rf_wdata_o and rf_whalf_o for that half.
REQ-030 rf_we_o SHALL be 1 only when the latched rf_write = 1, the latched rd != 0, and the op is ADD..PASS_A; otherwise it is 0.
REQ-031 SLT/SLTU write-back:
- lower accept: no write;
- HI accept: next edge writes upper half = 0;
- FLUSH: next edge writes lower half = {0, lt}.
REQ-032 Branch ops (8-13) SHALL never write the register file.
- The edge after the HI accept sets br_valid_o = 1 and br_taken_o = result for one cycle.
- BNE, BGE and BGEU use the inverted condition.
REQ-033 Reserved ops (14-15) SHALL behave as PASS_A and set err_o.
REQ-034 first_half_i = 1 accepted in HI SHALL:
- discard the pending instruction with no upper write;
- restart as a new LO accept;
- set err_o.
REQ-035 first_half_i = 0 accepted in LO SHALL be dropped with no write, and SHALL set err_o.
REQ-036 err_o SHALL remain 1 until reset.

Reset
REQ-037 On rst_n = 0, the block SHALL immediately, independent of clk:
- enter LO;
- clear latched carry, equal flag, op, rd and rf_write;
- drive rf_we_o, rf_waddr_o, rf_wdata_o, rf_whalf_o, br_valid_o, br_taken_o and err_o to 0.
REQ-038 Reset asserted in HI or FLUSH SHALL abandon the instruction; no further write-back for it SHALL occur after release.

Verification
REQ-039 ADD, rd = 5, A = 0x0001FFFF, B = 0x00000001 -> lower write 0x0000 (whalf 0), then upper write 0x0002 (whalf 1), each one cycle after its accept.
REQ-040 SUB, rd = 3, A = 0x00010000, B = 0x00000001 -> writes 0xFFFF then 0x0000.
REQ-041 SLT, rd = 7, A = 0xFFFFFFFF, B = 0x00000001 -> no lower write at LO accept; upper 0x0000; then lower 0x0001; ready_o = 0 for exactly one cycle. SLTU with the same operands -> lower 0x0000.
REQ-042 BEQ, A = 0x12340000, B = 0x12340001 -> br_valid_o pulse with br_taken_o = 0, rf_we_o stays 0. BNE with the same operands -> br_taken_o = 1.
REQ-043 Protocol error: two consecutive first_half_i = 1 accepts (ADD rd = 2) -> no upper write for the first; err_o = 1 and held; the second completes normally.
REQ-044 Reset pulsed one cycle after an ADD lower accept -> outputs 0 immediately; no upper write; next lower accept is treated as a new instruction.

Source files
------------

// File: rtl/exe_serial_alu.sv
// Half-word serial ALU: takes a 2*HALF_W-bit operation as a lower then an upper
// half-word, writes results back per half and resolves branch decisions.
module exe_serial_alu #(
  parameter int RF_ADDR_W = 5,
  parameter int HALF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 first_half_i,
  input  logic [3:0]           alu_op_i,
  input  logic [HALF_W-1:0]    alu_a_i,
  input  logic [HALF_W-1:0]    alu_b_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  input  logic                 rf_write_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [HALF_W-1:0]    rf_wdata_o,
  output logic                 rf_whalf_o,
  output logic                 br_valid_o,
  output logic                 br_taken_o,
  output logic                 err_o,
  output logic [1:0]           dbg_state_o
);

  // Handshake: a half-word transfers on a rising edge where valid_i && ready_o;
  // ready_o depends only on state, so it never reacts to valid_i combinationally.

  typedef enum logic [1:0] {S_LO = 2'd0, S_HI = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t                 r_state;
  logic [3:0]             r_op;
  logic [RF_ADDR_W-1:0]   r_rd;
  logic                   r_rf_write;
  logic                   r_carry;
  logic                   r_eq_lo;
  logic                   r_lt;

  logic                   w_accept;
  logic [3:0]             w_op;
  logic                   w_sub;
  logic                   w_cin;
  logic [HALF_W-1:0]      w_b_eff;
  logic [HALF_W:0]        w_sum;
  logic [HALF_W-1:0]      w_result;
  logic                   w_eq;
  logic                   w_lt_s;
  logic                   w_ltu;
  logic                   w_is_wr_op;
  logic                   w_is_slt;
  logic                   w_reserved;
  logic                   w_wr_en_lo;
  logic                   w_wr_en_hi;
  logic                   w_taken;

  assign ready_o     = (r_state != S_FLUSH);
  assign dbg_state_o = r_state;
  assign w_accept    = valid_i && ready_o;

  // A lower half always carries its own opcode; an upper half uses the latched one.
  assign w_op       = first_half_i ? alu_op_i : r_op;
  assign w_sub      = (w_op != 4'd0);
  assign w_cin      = first_half_i ? w_sub : r_carry;
  assign w_b_eff    = w_sub ? ~alu_b_i : alu_b_i;
  assign w_sum      = {1'b0, alu_a_i} + {1'b0, w_b_eff} + {{HALF_W{1'b0}}, w_cin};
  assign w_eq       = r_eq_lo && (alu_a_i == alu_b_i);
  assign w_lt_s     = (alu_a_i[HALF_W-1] != alu_b_i[HALF_W-1]) ? alu_a_i[HALF_W-1]
                                                               : w_sum[HALF_W-1];
  assign w_ltu      = ~w_sum[HALF_W];
  assign w_reserved = (w_op >= 4'd14);
  assign w_is_wr_op = (w_op <= 4'd7) || w_reserved;
  assign w_is_slt   = (w_op == 4'd5) || (w_op == 4'd6);
  assign w_wr_en_lo = rf_write_i && (rd_i != '0) && w_is_wr_op && !w_is_slt;
  assign w_wr_en_hi = r_rf_write && (r_rd != '0) && w_is_wr_op;

  always_comb begin
    w_result = '0;
    case (w_op)
      4'd0, 4'd1:          w_result = w_sum[HALF_W-1:0];
      4'd2:                w_result = alu_a_i & alu_b_i;
      4'd3:                w_result = alu_a_i | alu_b_i;
      4'd4:                w_result = alu_a_i ^ alu_b_i;
      4'd7, 4'd14, 4'd15:  w_result = alu_a_i;
      default:             w_result = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_op)
      4'd8:    w_taken = w_eq;
      4'd9:    w_taken = !w_eq;
      4'd10:   w_taken = w_lt_s;
      4'd11:   w_taken = !w_lt_s;
      4'd12:   w_taken = w_ltu;
      4'd13:   w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LO;
      r_op       <= '0;
      r_rd       <= '0;
      r_rf_write <= 1'b0;
      r_carry    <= 1'b0;
      r_eq_lo    <= 1'b0;
      r_lt       <= 1'b0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      rf_whalf_o <= 1'b0;
      br_valid_o <= 1'b0;
      br_taken_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rf_we_o    <= 1'b0;
      br_valid_o <= 1'b0;
      if (r_state == S_FLUSH) begin
        // Deferred SLT/SLTU lower write: the compare is only known after the upper half.
        rf_we_o    <= r_rf_write && (r_rd != '0);
        rf_waddr_o <= r_rd;
        rf_wdata_o <= {{(HALF_W-1){1'b0}}, r_lt};
        rf_whalf_o <= 1'b0;
        r_state    <= S_LO;
      end else if (w_accept) begin
        if (first_half_i) begin
          r_op       <= alu_op_i;
          r_rd       <= rd_i;
          r_rf_write <= rf_write_i;
          r_carry    <= w_sum[HALF_W];
          r_eq_lo    <= (alu_a_i == alu_b_i);
          if (w_wr_en_lo) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= rd_i;
            rf_wdata_o <= w_result;
            rf_whalf_o <= 1'b0;
          end
          if (w_reserved || (r_state == S_HI)) err_o <= 1'b1;
          r_state <= S_HI;
        end else if (r_state == S_HI) begin
          if (w_op >= 4'd8 && w_op <= 4'd13) begin
            br_valid_o <= 1'b1;
            br_taken_o <= w_taken;
          end else if (w_wr_en_hi) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= r_rd;
            rf_wdata_o <= w_is_slt ? '0 : w_result;
            rf_whalf_o <= 1'b1;
          end
          if (w_is_slt) begin
            r_lt    <= (w_op == 4'd5) ? w_lt_s : w_ltu;
            r_state <= S_FLUSH;
          end else begin
            r_state <= S_LO;
          end
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_serial_alu.sv
// Randomized and directed bench for exe_serial_alu with a 32-bit reference model.
module tb_exe_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        first_half_i = 1'b0;
  logic [3:0]  alu_op_i = '0;
  logic [15:0] alu_a_i = '0;
  logic [15:0] alu_b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        rf_write_i = 1'b0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [15:0] rf_wdata_o;
  logic        rf_whalf_o;
  logic        br_valid_o;
  logic        br_taken_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;
  logic [21:0] exp_q[$];
  logic        exp_br_q[$];

  exe_serial_alu #(.RF_ADDR_W(5), .HALF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .first_half_i(first_half_i), .alu_op_i(alu_op_i), .alu_a_i(alu_a_i),
    .alu_b_i(alu_b_i), .rd_i(rd_i), .rf_write_i(rf_write_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_whalf_o(rf_whalf_o),
    .br_valid_o(br_valid_o), .br_taken_o(br_taken_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole 32-bit operation, expected write-backs in order.
  task automatic model_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic wr);
    logic [31:0] res;
    logic we;
    logic lt;
    we = wr && (rd != 5'd0);
    res = 32'h0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      default: res = a;
    endcase
    case (op)
      4'd8:  exp_br_q.push_back(a == b);
      4'd9:  exp_br_q.push_back(a != b);
      4'd10: exp_br_q.push_back($signed(a) < $signed(b));
      4'd11: exp_br_q.push_back($signed(a) >= $signed(b));
      4'd12: exp_br_q.push_back(a < b);
      4'd13: exp_br_q.push_back(a >= b);
      4'd5, 4'd6: begin
        lt = (op == 4'd5) ? ($signed(a) < $signed(b)) : (a < b);
        if (we) begin
          exp_q.push_back({1'b1, rd, 16'h0000});
          exp_q.push_back({1'b0, rd, 15'h0, lt});
        end
      end
      default: begin
        if (we) begin
          exp_q.push_back({1'b0, rd, res[15:0]});
          exp_q.push_back({1'b1, rd, res[31:16]});
        end
      end
    endcase
    if (op >= 4'd14) exp_err = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_half(input logic first, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [4:0] rd, input logic wr);
    int waits;
    waits = 0;
    valid_i = 1'b1; first_half_i = first; alu_op_i = op;
    alu_a_i = a; alu_b_i = b; rd_i = rd; rf_write_i = wr;
    while (!ready_o && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout got ready=%0b expected 1", ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Upper half carries junk op/rd/wr: the DUT must use its latched values.
  task automatic do_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic wr);
    logic [3:0] jop;
    logic [4:0] jrd;
    logic       jwr;
    jop = 4'($urandom_range(0, 15));
    jrd = 5'($urandom_range(0, 31));
    jwr = 1'($urandom_range(0, 1));
    model_instr(op, a, b, rd, wr);
    send_half(1'b1, op, a[15:0], b[15:0], rd, wr);
    send_half(1'b0, jop, a[31:16], b[31:16], jrd, jwr);
    valid_i = 1'b0;
  endtask

  // Monitor: compares every write-back strobe and branch pulse with the scoreboard.
  initial begin
    logic [21:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rf_we_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected got half=%0b addr=%0d data=%0h expected no write",
                     rf_whalf_o, rf_waddr_o, rf_wdata_o);
          end else begin
            exp_w = exp_q.pop_front();
            if ({rf_whalf_o, rf_waddr_o, rf_wdata_o} !== exp_w) begin
              errors++;
              $display("FAIL wb_data got half=%0b addr=%0d data=%0h expected half=%0b addr=%0d data=%0h",
                       rf_whalf_o, rf_waddr_o, rf_wdata_o, exp_w[21], exp_w[20:16], exp_w[15:0]);
            end
          end
        end
        if (br_valid_o) begin
          checks++;
          if (exp_br_q.size() == 0) begin
            errors++;
            $display("FAIL br_unexpected got taken=%0b expected no branch", br_taken_o);
          end else if (br_taken_o !== exp_br_q.pop_front()) begin
            errors++;
            $display("FAIL br_taken got %0b expected %0b", br_taken_o, !br_taken_o);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        wr;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {rf_we_o, rf_waddr_o, rf_wdata_o, rf_whalf_o, br_valid_o, br_taken_o, err_o}, 0);
    check("reset_ready", ready_o, 1);
    check("reset_state", dbg_state_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_instr(4'd0, 32'h0001FFFF, 32'h00000001, 5'd5, 1'b1);
    do_instr(4'd1, 32'h00010000, 32'h00000001, 5'd3, 1'b1);
    do_instr(4'd5, 32'hFFFFFFFF, 32'h00000001, 5'd7, 1'b1);
    check("slt_flush_ready_low", ready_o, 0);
    @(posedge clk); #1;
    check("slt_flush_ready_high", ready_o, 1);
    do_instr(4'd6, 32'hFFFFFFFF, 32'h00000001, 5'd7, 1'b1);
    do_instr(4'd8, 32'h12340000, 32'h12340001, 5'd9, 1'b1);
    do_instr(4'd9, 32'h12340000, 32'h12340001, 5'd9, 1'b1);
    idle(2);
    check("err_clean_directed", err_o, exp_err);

    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 13));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: b = {a[31:16], 16'($urandom)};
        default: b = $urandom;
      endcase
      rd = 5'($urandom_range(0, 31));
      wr = ($urandom_range(0, 3) != 0);
      do_instr(op, a, b, rd, wr);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    check("err_clean_random", err_o, exp_err);

    // Two lower halves in a row: first is abandoned after its lower write.
    model_instr(4'd0, 32'h00030005, 32'h00010002, 5'd2, 1'b1);
    void'(exp_q.pop_back());
    send_half(1'b1, 4'd0, 16'h0005, 16'h0002, 5'd2, 1'b1);
    exp_err = 1'b1;
    do_instr(4'd0, 32'h00030005, 32'h00010002, 5'd2, 1'b1);
    idle(4);
    check("err_double_lower", err_o, 1);
    check("err_held", err_o, exp_err);

    // Upper half arriving in LO is dropped.
    send_half(1'b0, 4'd0, 16'h1111, 16'h2222, 5'd4, 1'b1);
    idle(3);
    check("err_upper_in_lo", err_o, 1);
    check("state_after_drop", dbg_state_o, 0);

    do_instr(4'd15, 32'hCAFE1234, 32'h00000000, 5'd6, 1'b1);
    idle(2);
    check("err_reserved", err_o, exp_err);

    // Reset one cycle after a lower accept abandons the instruction.
    model_instr(4'd0, 32'h0004A5A5, 32'h00010101, 5'd5, 1'b1);
    void'(exp_q.pop_back());
    send_half(1'b1, 4'd0, 16'hA5A5, 16'h0101, 5'd5, 1'b1);
    valid_i = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check("async_reset_outputs", {rf_we_o, rf_waddr_o, rf_wdata_o, rf_whalf_o, br_valid_o, br_taken_o, err_o}, 0);
    check("async_reset_state", dbg_state_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    check("err_after_reset", err_o, 0);
    do_instr(4'd0, 32'h0004A5A5, 32'h00010101, 5'd5, 1'b1);
    idle(4);
    check("err_final", err_o, exp_err);
    check("wb_queue_drained", exp_q.size(), 0);
    check("br_queue_drained", exp_br_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
